wb_cmd_master: RTL and testbench

//  Wishbone B4 classic master that drives the user-area slave port (cyc/stb/we/sel/adr/dat -> ack/dat).

---
 rtl/wb_cmd_master.sv | 180 ++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone B4 classic single-transfer master driven by a cmd/rsp handshake
module wb_cmd_master #(
  parameter int                ADR_W   = 32,
  parameter int                DAT_W   = 32,
  parameter int                TIMEOUT = 255,
  parameter logic [DAT_W-1:0]  TO_DATA = DAT_W'(32'hDEAD_BEEF)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rstn_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADR_W-1:0]     cmd_adr,
  input  logic [DAT_W-1:0]     cmd_dat,
  input  logic [DAT_W/8-1:0]   cmd_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DAT_W-1:0]     rsp_dat,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [DAT_W/8-1:0]   wbm_sel_o,
  output logic [ADR_W-1:0]     wbm_adr_o,
  output logic [DAT_W-1:0]     wbm_dat_o,
  input  logic [DAT_W-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i
);

  localparam int               SEL_W   = DAT_W / 8;
  localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic               w_accept;
  logic               w_ack;
  logic               w_timeout;
  logic               w_to_hit;
  logic               w_rsp_done;
  logic               r_cyc;
  logic               r_we;
  logic [SEL_W-1:0]   r_sel;
  logic [ADR_W-1:0]   r_adr;
  logic [DAT_W-1:0]   r_dat_o;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rsp_valid;
  logic [DAT_W-1:0]   r_rsp_dat;
  logic               r_rsp_err;

  // Assertion reaches every flop at once; release is aligned to the clock.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_to_hit = TO_EN && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        // A late ack on the final allowed cycle still completes normally.
        if (wbm_ack_i) begin
          w_ack       = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dat_o <= '0;
    end else begin
      if (w_accept) begin
        r_cyc   <= 1'b1;
        r_we    <= cmd_we;
        r_sel   <= cmd_sel;
        r_adr   <= cmd_adr;
        r_dat_o <= cmd_dat;
      end else if (w_ack || w_timeout) begin
        r_cyc   <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUS) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_ack) begin
        r_rsp_valid <= 1'b1;
        r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
        r_rsp_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_dat   <= TO_DATA;
        r_rsp_err   <= 1'b1;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_BUS) || (r_state == S_RESP);
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat_o;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

  logic        wb_clk_i;
  logic        wb_rstn_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  int n_chk;
  int n_err;
  int w;

  wb_cmd_master #(
    .ADR_W   (32),
    .DAT_W   (32),
    .TIMEOUT (16),
    .TO_DATA (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rstn_i (wb_rstn_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Present one command for exactly one acceptance edge.
  task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    check("cmd_ready_before_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_after_handshake", rsp_valid, 0);
    check("cmd_ready_after_handshake", cmd_ready, 1);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    wb_rstn_i = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    wbm_dat_i = '0;
    wbm_ack_i = 1'b0;

    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_we_sel", {wbm_we_o, wbm_sel_o}, 0);
    check("rst_rsp", {rsp_err, rsp_dat}, 0);
    wb_rstn_i = 1'b1;
    tick(); tick(); tick();

    // Write, slave acks on the fourth strobe cycle.
    issue_cmd(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF);
    check("wr_cyc", wbm_cyc_o, 1);
    check("wr_stb", wbm_stb_o, 1);
    check("wr_we", wbm_we_o, 1);
    check("wr_adr", wbm_adr_o, 32'h3000_0004);
    check("wr_dat", wbm_dat_o, 32'hA5A5_0001);
    check("wr_sel", wbm_sel_o, 4'hF);
    check("wr_busy", busy, 1);
    check("wr_cmd_ready_bus", cmd_ready, 0);
    w = 0;
    while (wbm_stb_o && w < 40) begin
      w++;
      if (w == 4) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_FFFF;
      end
      tick();
      wbm_ack_i = 1'b0;
    end
    check("wr_stb_width", w, 4);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_dat", rsp_dat, 0);
    consume();

    // Read, combinational ack in the first strobe cycle; then stray ack in RESP.
    issue_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    check("rd_cyc", wbm_cyc_o, 1);
    check("rd_we", wbm_we_o, 0);
    check("rd_rsp_valid_early", rsp_valid, 0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    tick();
    wbm_ack_i = 1'b0;
    check("rd_rsp_valid_n2", rsp_valid, 1);
    check("rd_rsp_dat", rsp_dat, 32'h1234_5678);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_cyc_drop", wbm_cyc_o, 0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0000_0BAD;
    tick();
    wbm_ack_i = 1'b0;
    check("stray_resp_dat", rsp_dat, 32'h1234_5678);
    check("stray_resp_valid", rsp_valid, 1);
    check("stray_resp_cyc", wbm_cyc_o, 0);
    consume();

    // Timeout: no ack ever.
    issue_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h3);
    w = 0;
    while (wbm_stb_o && w < 100) begin
      w++;
      tick();
    end
    check("to_stb_width", w, 16);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_dat", rsp_dat, 32'hDEAD_BEEF);

    // Backpressure on the timeout response with a second command waiting.
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0008;
    cmd_dat   = 32'h5A5A_0002;
    cmd_sel   = 4'hC;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_dat", {rsp_err, rsp_dat}, {1'b1, 32'hDEAD_BEEF});
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_cyc", wbm_cyc_o, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_rsp_valid_done", rsp_valid, 0);
    check("bp_no_accept_at_hs", wbm_cyc_o, 0);
    check("bp_cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("bp_second_cyc", wbm_cyc_o, 1);
    check("bp_second_adr", wbm_adr_o, 32'h3000_0008);
    check("bp_second_sel", wbm_sel_o, 4'hC);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check("bp_second_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 32'h0});
    consume();

    // Reset asserted between clock edges while strobe is high.
    issue_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    tick();
    check("mid_rst_cyc_before", wbm_cyc_o, 1);
    #2;
    wb_rstn_i = 1'b0;
    #1;
    check("mid_rst_cyc", wbm_cyc_o, 0);
    check("mid_rst_stb", wbm_stb_o, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_adr", wbm_adr_o, 0);
    tick();
    wb_rstn_i = 1'b1;
    tick(); tick(); tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    issue_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hCAFE_F00D;
    tick();
    wbm_ack_i = 1'b0;
    check("post_rst_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 32'hCAFE_F00D});
    consume();

    // Stray ack while idle.
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    tick(); tick();
    wbm_ack_i = 1'b0;
    check("stray_idle_cyc", wbm_cyc_o, 0);
    check("stray_idle_rsp_valid", rsp_valid, 0);
    check("stray_idle_busy", busy, 0);

    // Ack on the last allowed cycle wins over the timeout.
    issue_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    w = 0;
    while (wbm_stb_o && w < 100) begin
      w++;
      if (w == 16) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0BAD_CAFE;
      end
      tick();
      wbm_ack_i = 1'b0;
    end
    check("race_stb_width", w, 16);
    check("race_rsp_err", rsp_err, 0);
    check("race_rsp_dat", rsp_dat, 32'h0BAD_CAFE);
    consume();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
